// File: rtl/fir_stim_gen.sv
// Stimulus source for FIR_Filter x_in: step, pulse, zero tail, then negative step.
// Optional macro FIR_STIM_LOOP_EN repeats the sequence until reset.
module fir_stim_gen #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned STEP_LEN  = 10,
    parameter int unsigned PULSE_LEN = 1,
    parameter int unsigned ZERO_LEN  = 10,
    parameter int unsigned NEG_LEN   = 8,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] amp_step,
    input  logic [DATA_W-1:0] amp_pulse,
    input  logic [DATA_W-1:0] amp_neg,
    output logic [DATA_W-1:0] x_out,
    output logic              x_valid,
    output logic              busy,
    output logic              done,
    output logic [2:0]        phase
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        STEP  = 3'd1,
        PULSE = 3'd2,
        ZERO  = 3'd3,
        NEG   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] step_q, step_d;
    logic [DATA_W-1:0] pulse_q, pulse_d;
    logic [DATA_W-1:0] neg_q, neg_d;
    logic [DATA_W-1:0] x_out_d;
    logic              x_valid_d;
    logic              busy_d;
    logic              done_d;
    state_t            first_ph;
    state_t            next_ph;

    // First phase after s that has a nonzero length; IDLE when none remain.
    function automatic state_t phase_after(input state_t s);
        state_t r;
        r = IDLE;
        if ((s < NEG)   && (NEG_LEN   != 0)) r = NEG;
        if ((s < ZERO)  && (ZERO_LEN  != 0)) r = ZERO;
        if ((s < PULSE) && (PULSE_LEN != 0)) r = PULSE;
        if ((s < STEP)  && (STEP_LEN  != 0)) r = STEP;
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] last_idx(input state_t s);
        logic [CNT_W-1:0] r;
        case (s)
            STEP:    r = CNT_W'(STEP_LEN - 1);
            PULSE:   r = CNT_W'(PULSE_LEN - 1);
            ZERO:    r = CNT_W'(ZERO_LEN - 1);
            NEG:     r = CNT_W'(NEG_LEN - 1);
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] sample_of(input state_t s,
                                                    input logic [DATA_W-1:0] a_step,
                                                    input logic [DATA_W-1:0] a_pulse,
                                                    input logic [DATA_W-1:0] a_neg);
        logic [DATA_W-1:0] r;
        case (s)
            STEP:    r = a_step;
            PULSE:   r = a_pulse;
            NEG:     r = a_neg;
            default: r = '0;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            step_q  <= '0;
            pulse_q <= '0;
            neg_q   <= '0;
            x_out   <= '0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            pulse_q <= pulse_d;
            neg_q   <= neg_d;
            x_out   <= x_out_d;
            x_valid <= x_valid_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    assign phase = state_q;

    // Phase sequencing; every output is loaded here one cycle ahead of use.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        step_d    = step_q;
        pulse_d   = pulse_q;
        neg_d     = neg_q;
        x_out_d   = x_out;
        x_valid_d = x_valid;
        busy_d    = busy;
        done_d    = 1'b0;
        first_ph  = phase_after(IDLE);
        next_ph   = phase_after(state_q);

        case (state_q)
            IDLE: begin
                x_out_d   = '0;
                x_valid_d = 1'b0;
                busy_d    = 1'b0;
                cnt_d     = '0;
                if (start) begin
                    step_d  = amp_step;
                    pulse_d = amp_pulse;
                    neg_d   = amp_neg;
                    if (first_ph != IDLE) begin
                        state_d   = first_ph;
                        cnt_d     = last_idx(first_ph);
                        x_out_d   = sample_of(first_ph, amp_step, amp_pulse, amp_neg);
                        x_valid_d = 1'b1;
                        busy_d    = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            STEP, PULSE, ZERO, NEG: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (next_ph != IDLE) begin
                    state_d = next_ph;
                    cnt_d   = last_idx(next_ph);
                    x_out_d = sample_of(next_ph, step_q, pulse_q, neg_q);
                end else begin
`ifdef FIR_STIM_LOOP_EN
                    // Wrap to the first phase; done marks the first sample of each repeat.
                    state_d = first_ph;
                    cnt_d   = last_idx(first_ph);
                    x_out_d = sample_of(first_ph, step_q, pulse_q, neg_q);
                    done_d  = 1'b1;
`else
                    state_d   = IDLE;
                    cnt_d     = '0;
                    x_out_d   = '0;
                    x_valid_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
`endif
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                x_out_d   = '0;
                x_valid_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

endmodule
